layered_objects_mux: RTL
========================

Name: layered_objects_mux

Overview:
Parametrised, pipelined priority compositor for the VGA path. It merges NUM_LAYERS object layers over a background into one registered pixel. Beyond fixed-priority selection, it adds per-frame layer enables, a transparent-colour key, and collision detection between layer 0 (player) and every other layer. It sits between the object drawers and the VGA controller.

Parameters:
NUM_LAYERS, 8, number of object layers (2..16); index 0 has the highest priority.
RGB_W, 8, pixel colour width in bits.
TRANSP_EN, 1, 1 means a layer pixel equal to TRANSPARENT_RGB is treated as not drawing.
TRANSPARENT_RGB, 8'hFF, colour key value (RGB_W bits).
Localparam IDX_W = $clog2(NUM_LAYERS).

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse at frame start
layerEnable  in  NUM_LAYERS  enable mask, sampled only on startOfFrame
drawReq  in  NUM_LAYERS  per-layer drawing request for the current pixel
layerRGB  in  NUM_LAYERS*RGB_W  flattened colours; layer i occupies bits [i*RGB_W +: RGB_W]
bgRGB  in  RGB_W  background colour (lowest priority)
RGBOut  out  RGB_W  composited pixel
topValid  out  1  RGBOut comes from an object layer, not from the background
topLayer  out  IDX_W  index of the winning layer; 0 when topValid=0
collisionPulse  out  NUM_LAYERS  bit i (i>=1) = layer 0 and layer i both effective on this pixel; bit 0 is always 0
frameCollision  out  NUM_LAYERS  sticky collision set of the previous frame

Behaviour:
- All state changes occur on posedge clk. Reset is synchronous: resetN=0 at a clock edge sets every register to its reset value and overrides all other inputs that cycle.
- Reset values:
  - RGBOut, topValid, topLayer, collisionPulse, frameCollision = 0.
  - Internal enMask = all ones.
  - Internal sticky = 0.
  - Pipeline registers = 0.
- enMask <= layerEnable on a cycle with startOfFrame=1. The new mask affects pixels presented from the next cycle onward.
- Effective request: eff[i] = drawReq[i] & enMask[i] & ~(TRANSP_EN & (layerRGB[i] == TRANSPARENT_RGB)).
- Stage 1 (registered):
  - win = lowest i with eff[i]=1.
  - s1Valid = |eff.
  - s1RGB = layerRGB[win], or bgRGB if none.
  - s1Idx = win, or 0.
  - s1Eff = eff.
- Stage 2 (registered outputs): RGBOut <= s1RGB; topValid <= s1Valid; topLayer <= s1Idx.
- Latency: inputs presented at cycle N appear on RGBOut at cycle N+2. Throughput is one pixel per clock with no stalls.
- Collision:
  - hit[i] = s1Eff[0] & s1Eff[i] for i>=1; hit[0] = 0.
  - collisionPulse <= hit, aligned with RGBOut.
  - Collision uses eff, so disabled or transparent pixels never collide.
  - Lower-priority layers collide even when hidden by an intermediate layer.
- Sticky/frame logic:
  - If startOfFrame=1: frameCollision <= sticky | hit; sticky <= 0.
  - Else: sticky <= sticky | hit.
  - A hit coinciding with startOfFrame belongs to the closing frame.
  - The first startOfFrame after reset yields frameCollision = hits since reset.
- Reset mid-frame discards in-flight pixels and the sticky set. RGBOut returns 0 until real data drains through (two cycles after reset release).
- Layers with drawReq=1 but masked are invisible: the next effective layer, or bgRGB, wins.
- TRANSP_EN=0: colour equal to TRANSPARENT_RGB is drawn normally.

Test Plan:
1. Priority (NUM_LAYERS=8): drawReq=8'b1010_0100, layer2=8'h1C, layer5=8'hE0, bg=8'h03 -> two cycles later RGBOut=8'h1C, topLayer=2, topValid=1. With drawReq=0 -> RGBOut=8'h03, topValid=0.
2. Frame enable: pulse startOfFrame with layerEnable=8'hFB, keep drawReq=8'b0010_0100 -> from the following pixel RGBOut=layer5 colour 8'hE0, topLayer=5. Pixels presented in the startOfFrame cycle still show layer2.
3. Transparency: layer1 drawReq=1 with colour 8'hFF, layer3 drawReq=1 with colour 8'h55 -> RGBOut=8'h55, topLayer=3. Repeat with TRANSP_EN=0 -> RGBOut=8'hFF, topLayer=1.
4. Collision: drawReq=8'b0100_0001 for 3 cycles, then 0 -> collisionPulse=8'h40 for exactly 3 cycles, aligned with RGBOut. Next startOfFrame -> frameCollision=8'h40. Following startOfFrame with no hits -> frameCollision=0.
5. Simultaneous event: layer0 and layer4 hit arriving in stage 2 on the same cycle as startOfFrame, with sticky=8'h02 -> frameCollision=8'h12, sticky cleared. The next frame reports 0 if no further hits occur.
6. Reset mid-operation: resetN=0 for one cycle while collisions and a masked enMask are active -> the next cycle shows all outputs 0 and enMask all ones (a masked layer is drawn again). frameCollision stays 0 at the next startOfFrame if there are no new hits.

Source files
------------

// File: rtl/layered_objects_mux.sv
// Pipelined priority compositor: merges object layers over a background with
// per-frame layer enables, a colour key, and player-vs-layer collision tracking.
module layered_objects_mux #(
  parameter int unsigned       NUM_LAYERS      = 8,
  parameter int unsigned       RGB_W           = 8,
  parameter bit                TRANSP_EN       = 1'b1,
  parameter logic [RGB_W-1:0]  TRANSPARENT_RGB = 8'hFF,
  localparam int unsigned      IDX_W           = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            bgRGB,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        topValid,
  output logic [IDX_W-1:0]            topLayer,
  output logic [NUM_LAYERS-1:0]       collisionPulse,
  output logic [NUM_LAYERS-1:0]       frameCollision
);

  logic [NUM_LAYERS-1:0] en_mask_q;
  logic [NUM_LAYERS-1:0] sticky_q;

  logic [NUM_LAYERS-1:0] s1_eff_q,   s1_eff_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [RGB_W-1:0]      s1_rgb_q,   s1_rgb_d;
  logic [IDX_W-1:0]      s1_idx_q,   s1_idx_d;
  logic [NUM_LAYERS-1:0] hit_c;

  // Effective requests, fixed-priority winner, and player collisions from stage 1.
  always_comb begin
    s1_eff_d   = '0;
    s1_rgb_d   = bgRGB;
    s1_idx_d   = '0;
    s1_valid_d = 1'b0;
    hit_c      = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      s1_eff_d[i] = drawReq[i] & en_mask_q[i] &
                    ~(TRANSP_EN & (layerRGB[i*RGB_W +: RGB_W] == TRANSPARENT_RGB));
    end
    // Walk from lowest priority upward so layer 0 overwrites last.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_eff_d[i]) begin
        s1_rgb_d = layerRGB[i*RGB_W +: RGB_W];
        s1_idx_d = IDX_W'(i);
      end
    end
    s1_valid_d = |s1_eff_d;
    hit_c      = s1_eff_q & {NUM_LAYERS{s1_eff_q[0]}};
    hit_c[0]   = 1'b0;
  end

  // Mask, two pipeline stages, and frame-level collision bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      en_mask_q      <= '1;
      sticky_q       <= '0;
      s1_eff_q       <= '0;
      s1_valid_q     <= 1'b0;
      s1_rgb_q       <= '0;
      s1_idx_q       <= '0;
      RGBOut         <= '0;
      topValid       <= 1'b0;
      topLayer       <= '0;
      collisionPulse <= '0;
      frameCollision <= '0;
    end else begin
      s1_eff_q       <= s1_eff_d;
      s1_valid_q     <= s1_valid_d;
      s1_rgb_q       <= s1_rgb_d;
      s1_idx_q       <= s1_idx_d;
      RGBOut         <= s1_rgb_q;
      topValid       <= s1_valid_q;
      topLayer       <= s1_idx_q;
      collisionPulse <= hit_c;
      if (startOfFrame) begin
        en_mask_q      <= layerEnable;
        frameCollision <= sticky_q | hit_c;
        sticky_q       <= '0;
      end else begin
        sticky_q       <= sticky_q | hit_c;
      end
    end
  end

endmodule
